// File: rtl/fcp_pkg.sv
// ============================================================================
// Module  : fcp_pkg
// Brief   : FCP word layout shared by the transmit and receive adapters.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fcp_pkg;

    localparam int FCP_FCCL_LSB    = 0;
    localparam int FCP_QLEN_LSB    = 32;
    localparam int FCP_FCCR_LSB    = 64;
    localparam int FCP_VC_LSB      = 96;
    localparam int FCP_FIELD_WIDTH = 32;

    typedef logic [FCP_FIELD_WIDTH-1:0] fcp_field_t;

    // Saturating increment used by the statistics counters.
    function automatic fcp_field_t fcp_sat_inc(input fcp_field_t value);
        return (value == '1) ? value : value + fcp_field_t'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fcp_source_packer_if.sv
// ============================================================================
// Module  : fcp_upd_if / fcp_axis_if
// Brief   : Credit-update input bundle and FCP AXI-Stream output bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fcp_upd_if #(
    parameter int QUEUE_INDEX_WIDTH = 15,
    parameter int STAT_WIDTH        = 32
);
    logic                         fcp_valid;
    logic                         fcp_ready;
    logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc;
    logic [STAT_WIDTH-1:0]        fcp_fccl;
    logic [STAT_WIDTH-1:0]        fcp_qlen;
    logic [STAT_WIDTH-1:0]        fcp_fccr;

    modport master (
        output fcp_valid, fcp_vc, fcp_fccl, fcp_qlen, fcp_fccr,
        input  fcp_ready
    );

    modport slave (
        input  fcp_valid, fcp_vc, fcp_fccl, fcp_qlen, fcp_fccr,
        output fcp_ready
    );
endinterface

interface fcp_axis_if #(
    parameter int AXIS_WIDTH = 512
);
    logic [AXIS_WIDTH-1:0] m_axis_fcp_tdata;
    logic                  m_axis_fcp_tvalid;
    logic                  m_axis_fcp_tlast;
    logic                  m_axis_fcp_tready;

    modport master (
        output m_axis_fcp_tdata, m_axis_fcp_tvalid, m_axis_fcp_tlast,
        input  m_axis_fcp_tready
    );

    modport slave (
        input  m_axis_fcp_tdata, m_axis_fcp_tvalid, m_axis_fcp_tlast,
        output m_axis_fcp_tready
    );
endinterface

`default_nettype wire

// File: rtl/fcp_msg_fifo.sv
// ============================================================================
// Module  : fcp_msg_fifo
// Brief   : Show-ahead synchronous FIFO of packed (unpadded) FCP messages.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fcp_msg_fifo #(
    parameter int FIFO_ADDR_WIDTH = 3,
    parameter int DATA_WIDTH      = 111
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_wr_en,
    input  wire logic [DATA_WIDTH-1:0] i_wr_data,
    input  wire logic                  i_rd_en,
    output logic      [DATA_WIDTH-1:0] o_rd_data,
    output logic                       o_empty
);

    localparam int c_DEPTH = 1 << FIFO_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]    r_mem [c_DEPTH];
    // Extra MSB distinguishes full from empty when the address bits match.
    logic [FIFO_ADDR_WIDTH:0] r_wr_ptr;
    logic [FIFO_ADDR_WIDTH:0] r_rd_ptr;

    logic w_full;
    logic w_do_wr;
    logic w_do_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_ADDR_WIDTH] != r_rd_ptr[FIFO_ADDR_WIDTH]) &&
                     (r_wr_ptr[FIFO_ADDR_WIDTH-1:0] == r_rd_ptr[FIFO_ADDR_WIDTH-1:0]);
    assign w_do_wr = i_wr_en && !w_full;
    assign w_do_rd = i_rd_en && !o_empty;

    assign o_rd_data = r_mem[r_rd_ptr[FIFO_ADDR_WIDTH-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_wr) begin
                r_mem[r_wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= i_wr_data;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fcp_source_packer.sv
// ============================================================================
// Module  : fcp_source_packer
// Brief   : Packs per-VC credit updates into single-beat FCP AXI-Stream words.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fcp_source_packer
    import fcp_pkg::*;
#(
    parameter int QUEUE_INDEX_WIDTH = 15,
    parameter int STAT_WIDTH        = 32,
    parameter int AXIS_WIDTH        = 512,
    parameter int FIFO_ADDR_WIDTH   = 3
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    fcp_upd_if.slave                   fcp,
    fcp_axis_if.master                 m_axis_fcp,
    output logic      [STAT_WIDTH-1:0] stat_sent,
    output logic      [STAT_WIDTH-1:0] stat_dropped
);

    localparam int c_MSG_WIDTH  = FCP_VC_LSB + QUEUE_INDEX_WIDTH;
    localparam int c_CNT_WIDTH  = FIFO_ADDR_WIDTH + 1;
    localparam logic [c_CNT_WIDTH-1:0] c_FULL_COUNT =
        c_CNT_WIDTH'((1 << FIFO_ADDR_WIDTH) + 1);

    generate
        if ((c_MSG_WIDTH > AXIS_WIDTH) || (STAT_WIDTH != FCP_FIELD_WIDTH) ||
            (FIFO_ADDR_WIDTH < 1)) begin : g_param_error
            $error("fcp_source_packer: illegal parameter combination");
        end
    endgenerate

    logic [c_MSG_WIDTH-1:0] w_msg;
    logic [c_MSG_WIDTH-1:0] w_fifo_rd_data;
    logic [c_MSG_WIDTH-1:0] r_msg;
    logic [AXIS_WIDTH-1:0]  w_tdata;
    logic                   r_tvalid;
    logic [c_CNT_WIDTH-1:0] r_count;
    logic [STAT_WIDTH-1:0]  r_stat_sent;
    logic [STAT_WIDTH-1:0]  r_stat_dropped;

    logic w_ready;
    logic w_wr;
    logic w_xfer;
    logic w_load;
    logic w_fifo_empty;
    logic w_fifo_wr;
    logic w_fifo_rd;
    logic w_drop;

    always_comb begin
        w_msg = '0;
        w_msg[FCP_FCCL_LSB +: FCP_FIELD_WIDTH]   = fcp.fcp_fccl;
        w_msg[FCP_QLEN_LSB +: FCP_FIELD_WIDTH]   = fcp.fcp_qlen;
        w_msg[FCP_FCCR_LSB +: FCP_FIELD_WIDTH]   = fcp.fcp_fccr;
        w_msg[FCP_VC_LSB   +: QUEUE_INDEX_WIDTH] = fcp.fcp_vc;
    end

    // Occupancy covers the FIFO plus the output register.
    assign w_ready = (r_count != c_FULL_COUNT);
    assign w_wr    = fcp.fcp_valid && w_ready;
    assign w_drop  = fcp.fcp_valid && !w_ready;
    assign w_xfer  = r_tvalid && m_axis_fcp.m_axis_fcp_tready;
    assign w_load  = !r_tvalid || w_xfer;

    // FIFO head has priority; the incoming update bypasses only when the FIFO is empty.
    assign w_fifo_rd = w_load && !w_fifo_empty;
    assign w_fifo_wr = w_wr && !(w_load && w_fifo_empty);

    fcp_msg_fifo #(
        .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH),
        .DATA_WIDTH      (c_MSG_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (w_msg),
        .i_rd_en   (w_fifo_rd),
        .o_rd_data (w_fifo_rd_data),
        .o_empty   (w_fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tvalid <= 1'b0;
            r_msg    <= '0;
        end else if (w_load) begin
            if (!w_fifo_empty) begin
                r_msg    <= w_fifo_rd_data;
                r_tvalid <= 1'b1;
            end else if (w_wr) begin
                r_msg    <= w_msg;
                r_tvalid <= 1'b1;
            end else begin
                r_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_wr && !w_xfer) begin
            r_count <= r_count + 1'b1;
        end else if (w_xfer && !w_wr) begin
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_sent    <= '0;
            r_stat_dropped <= '0;
        end else begin
            if (w_xfer) begin
                r_stat_sent <= fcp_sat_inc(r_stat_sent);
            end
            if (w_drop) begin
                r_stat_dropped <= fcp_sat_inc(r_stat_dropped);
            end
        end
    end

    always_comb begin
        w_tdata                  = '0;
        w_tdata[c_MSG_WIDTH-1:0] = r_msg;
    end

    assign fcp.fcp_ready                = w_ready;
    assign m_axis_fcp.m_axis_fcp_tdata  = w_tdata;
    assign m_axis_fcp.m_axis_fcp_tvalid = r_tvalid;
    assign m_axis_fcp.m_axis_fcp_tlast  = 1'b1;
    assign stat_sent                    = r_stat_sent;
    assign stat_dropped                 = r_stat_dropped;

endmodule

`default_nettype wire
